// File: rtl/shader_core_p.sv
// rtl/shader_core_p.sv - two-stage shader core with bypassed register file, write-back export and HALT/resume
module shader_core_p #(
    parameter  int DATA_W   = 16,
    parameter  int NUM_REGS = 8,
    localparam int RA_W     = $clog2(NUM_REGS),
    localparam int INSTR_W  = 4 + 3 * RA_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [INSTR_W-1:0] instr,
    input  logic               instr_valid,
    output logic               instr_ready,
    input  logic               resume,
    output logic               wb_valid,
    output logic [RA_W-1:0]    wb_addr,
    output logic [DATA_W-1:0]  wb_data,
    output logic               halted
);

    localparam int SH_W = $clog2(DATA_W);

    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_AND  = 4'h3;
    localparam logic [3:0] OP_OR   = 4'h4;
    localparam logic [3:0] OP_XOR  = 4'h5;
    localparam logic [3:0] OP_SHL  = 4'h6;
    localparam logic [3:0] OP_SHR  = 4'h7;
    localparam logic [3:0] OP_LDI  = 4'h8;
    localparam logic [3:0] OP_MOV  = 4'h9;
    localparam logic [3:0] OP_HALT = 4'hF;

    typedef enum logic {S_RUN, S_HALTED} state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_ready;
    logic                r_id_valid;
    logic [INSTR_W-1:0]  r_id_instr;
    logic                r_wb_valid;
    logic [RA_W-1:0]     r_wb_addr;
    logic [DATA_W-1:0]   r_wb_data;
    logic [DATA_W-1:0]   r_regs [NUM_REGS];

    logic                w_accept;
    logic [3:0]          w_op;
    logic [RA_W-1:0]     w_wa;
    logic [RA_W-1:0]     w_ra;
    logic [RA_W-1:0]     w_rb;
    logic [DATA_W-1:0]   w_a;
    logic [DATA_W-1:0]   w_b;
    logic [DATA_W-1:0]   w_imm;
    logic [DATA_W-1:0]   w_res;
    logic                w_writes;
    logic                w_wr_en;

    assign w_accept = instr_valid & r_ready;
    assign w_op     = r_id_instr[INSTR_W-1 -: 4];
    assign w_wa     = r_id_instr[3*RA_W-1 -: RA_W];
    assign w_ra     = r_id_instr[2*RA_W-1 -: RA_W];
    assign w_rb     = r_id_instr[RA_W-1:0];

    // HALT is recognised at acceptance so that no further instruction slips in behind it.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_RUN:     if (w_accept && instr[INSTR_W-1 -: 4] == OP_HALT) w_state_nxt = S_HALTED;
            S_HALTED:  if (resume) w_state_nxt = S_RUN;
            default:   w_state_nxt = S_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_RUN;
            r_ready <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_ready <= (w_state_nxt == S_RUN);
        end
    end

    // Operand read: r0 reads zero, an in-flight write-back wins over the stored value.
    always_comb begin
        if (w_ra == '0)                                w_a = '0;
        else if (r_wb_valid && r_wb_addr == w_ra)      w_a = r_wb_data;
        else                                           w_a = r_regs[w_ra];
        if (w_rb == '0)                                w_b = '0;
        else if (r_wb_valid && r_wb_addr == w_rb)      w_b = r_wb_data;
        else                                           w_b = r_regs[w_rb];
    end

    always_comb begin
        w_imm              = '0;
        w_imm[2*RA_W-1:0]  = {w_ra, w_rb};
        w_res              = '0;
        w_writes           = 1'b1;
        case (w_op)
            OP_ADD:  w_res = w_a + w_b;
            OP_SUB:  w_res = w_a - w_b;
            OP_AND:  w_res = w_a & w_b;
            OP_OR:   w_res = w_a | w_b;
            OP_XOR:  w_res = w_a ^ w_b;
            OP_SHL:  w_res = w_a << w_b[SH_W-1:0];
            OP_SHR:  w_res = w_a >> w_b[SH_W-1:0];
            OP_LDI:  w_res = w_imm;
            OP_MOV:  w_res = w_a;
            default: w_writes = 1'b0;
        endcase
    end

    assign w_wr_en = r_id_valid & w_writes & (w_wa != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_id_valid <= 1'b0;
            r_id_instr <= '0;
            r_wb_valid <= 1'b0;
            r_wb_addr  <= '0;
            r_wb_data  <= '0;
        end else begin
            r_id_valid <= w_accept;
            if (w_accept) r_id_instr <= instr;
            r_wb_valid <= w_wr_en;
            if (w_wr_en) begin
                r_wb_addr <= w_wa;
                r_wb_data <= w_res;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
        end else if (r_wb_valid) begin
            r_regs[r_wb_addr] <= r_wb_data;
        end
    end

    assign instr_ready = r_ready;
    assign halted      = (r_state == S_HALTED);
    assign wb_valid    = r_wb_valid;
    assign wb_addr     = r_wb_addr;
    assign wb_data     = r_wb_data;

endmodule
